fetch_queue: RTL and testbench

Instruction fetch queue between the PC register / instruction memory pair and the decode stage of the pipelined CPU. Each cycle the fetch side presents the current PC and the instruction word read at it. The queue buffers up to DEPTH such pairs, tagging each with an address-error flag, and hands them to decode under a valid/ready handshake. It also provides the stall signal back to the PC register and discards all buffered work on a control-flow redirect.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue_pc_addr_check.sv | 15 +
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: legal instruction window, NOP encoding, queue entry.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_PC_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_PC_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_pc_addr_check.sv
// Instruction-address legality check: misaligned or outside [PC_BASE, PC_LIMIT].
module pc_addr_check #(
  parameter logic [31:0] PC_BASE  = fetch_pkg::DEFAULT_PC_BASE,
  parameter logic [31:0] PC_LIMIT = fetch_pkg::DEFAULT_PC_LIMIT
) (
  input  logic [31:0] pc,
  output logic        adel
);

  // Unsigned range and word-alignment test.
  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers PC/instruction pairs between fetch and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_BASE  = DEFAULT_PC_BASE,
  parameter logic [31:0] PC_LIMIT = DEFAULT_PC_LIMIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_adel,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          in_adel;
  logic          push;
  logic          pop;
  fetch_entry_t  new_entry;
  fetch_entry_t  head_entry;

  pc_addr_check #(
    .PC_BASE  (PC_BASE),
    .PC_LIMIT (PC_LIMIT)
  ) u_pc_addr_check (
    .pc   (in_pc),
    .adel (in_adel)
  );

  // Handshake flags and the entry to store; faulting fetches carry a NOP.
  always_comb begin
    in_ready        = (count != FULL);
    out_valid       = (count != '0);
    push            = in_valid && in_ready;
    pop             = out_valid && out_ready;
    new_entry.pc    = in_pc;
    new_entry.instr = in_adel ? NOP : in_instr;
    new_entry.adel  = in_adel;
  end

  // Head entry presented to decode, forced to zero while empty.
  always_comb begin
    head_entry = mem[head];
    out_pc     = '0;
    out_instr  = '0;
    out_adel   = 1'b0;
    if (out_valid) begin
      out_pc    = head_entry.pc;
      out_instr = head_entry.instr;
      out_adel  = head_entry.adel;
    end
  end

  // Pointer, occupancy and storage update; reset clears storage, flush does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= new_entry;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with a few hand-written sequences.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic        flush;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .DEPTH    (4),
    .PC_BASE  (32'h0000_3000),
    .PC_LIMIT (32'h0000_6FFC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle plus the outputs expected during that cycle
  // (i.e. the state left by the previous rows).
  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_adel;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic fl, logic iv, logic [31:0] pc,
                              logic [31:0] instr, logic ordy, logic e_ir, logic e_ov,
                              logic [31:0] e_pc, logic [31:0] e_instr, logic e_adel,
                              logic [2:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_adel = e_adel; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_ir, input logic e_ov,
                            input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic e_adel, input logic [2:0] e_cnt);
    check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, ".out_pc"},    out_pc,         e_pc);
    check({tag, ".out_instr"}, out_instr,      e_instr);
    check({tag, ".out_adel"},  32'(out_adel),  32'(e_adel));
    check({tag, ".count"},     32'(count),     32'(e_cnt));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    //   rst fl iv pc            instr         ordy | ir ov pc            instr         adel cnt
    // Reset state and first fill with no pops; no bypass while empty.
    add(0, 0, 0, 32'h0,      32'h0,        0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 1, 32'h3000,   32'h3C010001, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 1, 32'h3004,   32'h34210002, 0,   1, 1, 32'h3000,   32'h3C010001, 0, 1);
    add(0, 0, 1, 32'h3008,   32'h00000000, 0,   1, 1, 32'h3000,   32'h3C010001, 0, 2);
    add(0, 0, 1, 32'h300C,   32'h11111111, 0,   1, 1, 32'h3000,   32'h3C010001, 0, 3);
    // Full: push attempt with pop -> only the pop happens.
    add(0, 0, 1, 32'h3010,   32'h22222222, 1,   0, 1, 32'h3000,   32'h3C010001, 0, 4);
    add(0, 0, 1, 32'h3014,   32'h33333333, 0,   1, 1, 32'h3004,   32'h34210002, 0, 3);
    // Drain, tail has wrapped to slot 0.
    add(0, 0, 0, 32'h0,      32'h0,        1,   0, 1, 32'h3004,   32'h34210002, 0, 4);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h3008,   32'h00000000, 0, 3);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h300C,   32'h11111111, 0, 2);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h3014,   32'h33333333, 0, 1);
    // Address errors, then the highest legal address.
    add(0, 0, 1, 32'h3002,   32'hFFFFFFFF, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 1, 32'h2FFC,   32'hFFFFFFFF, 1,   1, 1, 32'h3002,   32'h0,        1, 1);
    add(0, 0, 1, 32'h7000,   32'hFFFFFFFF, 1,   1, 1, 32'h2FFC,   32'h0,        1, 1);
    add(0, 0, 1, 32'h6FFC,   32'hFFFFFFFF, 1,   1, 1, 32'h7000,   32'h0,        1, 1);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h6FFC,   32'hFFFFFFFF, 0, 1);
    // Flush with concurrent push and pop.
    add(0, 0, 1, 32'h4000,   32'hAAAA0001, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 1, 32'h4004,   32'hAAAA0002, 0,   1, 1, 32'h4000,   32'hAAAA0001, 0, 1);
    add(0, 0, 1, 32'h4008,   32'hAAAA0003, 0,   1, 1, 32'h4000,   32'hAAAA0001, 0, 2);
    add(0, 1, 1, 32'h400C,   32'hAAAA0004, 1,   1, 1, 32'h4000,   32'hAAAA0001, 0, 3);
    add(0, 0, 1, 32'h5000,   32'hBBBB0001, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h5000,   32'hBBBB0001, 0, 1);
    // Reset from full, then a push shows one cycle later.
    add(0, 0, 1, 32'h3100,   32'h00000001, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 1, 32'h3104,   32'h00000002, 0,   1, 1, 32'h3100,   32'h00000001, 0, 1);
    add(0, 0, 1, 32'h3108,   32'h00000003, 0,   1, 1, 32'h3100,   32'h00000001, 0, 2);
    add(0, 0, 1, 32'h310C,   32'h00000004, 0,   1, 1, 32'h3100,   32'h00000001, 0, 3);
    add(1, 0, 1, 32'h3110,   32'h00000005, 1,   0, 1, 32'h3100,   32'h00000001, 0, 4);
    add(0, 0, 1, 32'h3000,   32'h3C010001, 0,   1, 0, 32'h0,      32'h0,        0, 0);
    add(0, 0, 0, 32'h0,      32'h0,        1,   1, 1, 32'h3000,   32'h3C010001, 0, 1);
    add(0, 0, 0, 32'h0,      32'h0,        0,   1, 0, 32'h0,      32'h0,        0, 0);

    // Two reset cycles before the table.
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy);
      expect_out($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_pc,
                 vecs[i].e_instr, vecs[i].e_adel, vecs[i].e_cnt);
    end

    // Sustained stream: one push and one pop every cycle, occupancy held at 1.
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 32'h3000 + 32'(4 * k), 32'hA5A50000 + 32'(k), 1);
      if (k == 0) begin
        expect_out("stream0", 1, 0, 32'h0, 32'h0, 0, 0);
      end else begin
        expect_out($sformatf("stream%0d", k), 1, 1, 32'h3000 + 32'(4 * (k - 1)),
                   32'hA5A50000 + 32'(k - 1), 0, 1);
      end
    end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    expect_out("stream_last", 1, 1, 32'h3000 + 32'(4 * 19), 32'hA5A50013, 0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    expect_out("stream_empty", 1, 0, 32'h0, 32'h0, 0, 0);

    // Flush from full restores in_ready on the next cycle.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 32'h6000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 0);
    end
    drive(0, 1, 0, 32'h0, 32'h0, 0);
    expect_out("full_flush", 0, 1, 32'h6000, 32'hC0DE0000, 0, 4);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    expect_out("after_flush", 1, 0, 32'h0, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
